// File: rtl/debounce_scheduler.sv
// ---------------------------------------------------------------------------
// debounce_scheduler
//
// Debounces four raw switch inputs with one shared sampler. A 2-bit slot
// counter, advanced by a prescaler tick, picks one channel per tick. Each
// channel keeps its own stability counter. A new level is accepted after
// STABLE_CNT consecutive samples that disagree with the current clean level.
// Every accepted change produces a one-cycle rise or fall pulse.
//
// Ports:
//   clk    in   1  system clock, rising edge
//   rst    in   1  asynchronous active-low reset
//   en     in   1  scheduler enable; 0 freezes prescaler, slot, counts, levels
//   sw_in  in   4  raw asynchronous switch levels, bit n = channel n
//   clean  out  4  debounced levels
//   rise   out  4  one-cycle pulse on clean 0->1
//   fall   out  4  one-cycle pulse on clean 1->0
//   slot   out  2  channel currently selected for sampling
// ---------------------------------------------------------------------------
module debounce_scheduler #(
  parameter int PRESCALE   = 4,  // clk cycles per slot tick, >= 1
  parameter int STABLE_CNT = 3,  // disagreeing samples to accept, 1..15
  parameter int CW         = 4   // stability counter width, holds STABLE_CNT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] sw_in,
  output logic [3:0] clean,
  output logic [3:0] rise,
  output logic [3:0] fall,
  output logic [1:0] slot
);

  // A prescaler of 1 still needs a 1-bit register; it simply stays at 0.
  localparam int              PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRE_LAST   = PW'(PRESCALE - 1);
  localparam logic [CW-1:0]   CNT_ACCEPT = CW'(STABLE_CNT);

  // What the shared sampler does to the selected channel this cycle.
  typedef enum logic [1:0] {
    ACT_IDLE,    // no tick: every channel holds
    ACT_CLEAR,   // sample agrees with clean level: restart the count
    ACT_COUNT,   // sample disagrees, not yet stable long enough
    ACT_ACCEPT   // sample disagrees for the STABLE_CNT-th time: take it
  } sample_act_e;

  // -------------------------------------------------------------------------
  // Two-flop synchroniser per channel. Runs regardless of en so the sampled
  // value is always current when sequencing resumes.
  // -------------------------------------------------------------------------
  logic [3:0] sync1;
  logic [3:0] sync2;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values; blocking here would collapse sync1/sync2 into
  // a single stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_in;
      sync2 <= sync1;
    end
  end

  // -------------------------------------------------------------------------
  // Prescaler and slot counter. tick marks the enabled cycle on which the
  // current slot is sampled; the slot advances at that same edge, so the
  // sample always uses the pre-increment slot value.
  // -------------------------------------------------------------------------
  logic [PW-1:0] pre;
  logic          tick;

  assign tick = en & (pre == PRE_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre  <= '0;
      slot <= '0;
    end else if (en) begin
      pre <= (pre == PRE_LAST) ? '0 : pre + PW'(1);
      if (tick) begin
        slot <= slot + 2'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Shared sample decision for the selected channel.
  // -------------------------------------------------------------------------
  logic [CW-1:0] cnt     [4];
  logic [CW-1:0] cnt_nxt [4];
  logic [3:0]    clean_nxt;
  logic [3:0]    rise_nxt;
  logic [3:0]    fall_nxt;
  logic          sel_sync;
  logic          sel_clean;
  logic [CW-1:0] cnt_inc;
  sample_act_e   act;

  assign sel_sync  = sync2[slot];
  assign sel_clean = clean[slot];
  assign cnt_inc   = cnt[slot] + CW'(1);

  // NOTE: every output of this block is given a default before any branch,
  // so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    act       = ACT_IDLE;
    cnt_nxt   = cnt;
    clean_nxt = clean;
    rise_nxt  = '0;
    fall_nxt  = '0;

    if (tick) begin
      if (sel_sync == sel_clean) begin
        act = ACT_CLEAR;
      end else if (cnt_inc == CNT_ACCEPT) begin
        act = ACT_ACCEPT;
      end else begin
        act = ACT_COUNT;
      end
    end

    case (act)
      ACT_CLEAR: cnt_nxt[slot] = '0;
      ACT_COUNT: cnt_nxt[slot] = cnt_inc;
      ACT_ACCEPT: begin
        cnt_nxt[slot]   = '0;
        clean_nxt[slot] = sel_sync;
        rise_nxt[slot]  = sel_sync;
        fall_nxt[slot]  = ~sel_sync;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Per-channel state. Pulses are registered unconditionally so a pending
  // pulse still clears on the next edge even while en is low; counts and
  // levels only change through a tick, which already requires en.
  // -------------------------------------------------------------------------
  // NOTE: the counter array is reset explicitly. It is four tiny registers,
  // not a RAM, and a mid-operation reset must discard partial counts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
      clean <= '0;
      rise  <= '0;
      fall  <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
      clean <= clean_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

endmodule

// File: tb/tb_debounce_scheduler.sv
// ---------------------------------------------------------------------------
// tb_debounce_scheduler
//
// Directed bench for debounce_scheduler with default parameters. Expected
// pulse events (edge number, rise/fall vectors, clean level afterwards) are
// queued as stimulus is applied; every cycle in which the DUT shows a pulse
// pops and compares the next expected event. Edge numbers count rising
// clock edges since the last reset release.
// ---------------------------------------------------------------------------
module tb_debounce_scheduler;

  typedef struct {
    int         cyc;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] clean;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] sw_in;
  logic [3:0] clean;
  logic [3:0] rise;
  logic [3:0] fall;
  logic [1:0] slot;

  int   total;
  int   bad;
  int   cyc;
  exp_t q[$];

  debounce_scheduler #(
    .PRESCALE  (4),
    .STABLE_CNT(3),
    .CW        (4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .sw_in(sw_in),
    .clean(clean),
    .rise (rise),
    .fall (fall),
    .slot (slot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic expect_pulse(input int c, input logic [3:0] r,
                              input logic [3:0] f, input logic [3:0] cl);
    exp_t e;
    e.cyc   = c;
    e.rise  = r;
    e.fall  = f;
    e.clean = cl;
    q.push_back(e);
  endtask

  // Advance one edge, sample 1 time unit later, and score any pulse.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    check("rise_fall_exclusive", 32'(rise & fall), 32'h0);
    if ((rise | fall) != 4'h0) begin
      if (q.size() == 0) begin
        check("unexpected_pulse", {24'h0, rise, fall}, 32'h0);
      end else begin
        e = q.pop_front();
        check("pulse_cyc", cyc, e.cyc);
        check("pulse_rise", 32'(rise), 32'(e.rise));
        check("pulse_fall", 32'(fall), 32'(e.fall));
        check("pulse_clean", 32'(clean), 32'(e.clean));
      end
    end else if (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      check("missing_pulse", {24'h0, rise, fall}, {24'h0, e.rise, e.fall});
    end
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  // Assert reset mid-operation, verify the asynchronous clear, then release
  // with the given switch levels already applied.
  task automatic do_reset(input logic [3:0] sw);
    rst   = 1'b0;
    sw_in = sw;
    #1;
    check("async_reset_outputs", {18'h0, clean, rise, fall, slot}, 32'h0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("held_reset_outputs", {18'h0, clean, rise, fall, slot}, 32'h0);
    end
    en  = 1'b1;
    rst = 1'b1;
    cyc = 0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    en    = 1'b1;

    // ---- Reset values with all switches high --------------------------------
    rst   = 1'b0;
    sw_in = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    check("reset_clean", 32'(clean), 32'h0);
    check("reset_rise", 32'(rise), 32'h0);
    check("reset_fall", 32'(fall), 32'h0);
    check("reset_slot", 32'(slot), 32'h0);

    // ---- Clean press on ch0, bounce on ch1 ----------------------------------
    sw_in = 4'b0011;
    rst   = 1'b1;
    cyc   = 0;
    expect_pulse(36, 4'b0001, 4'b0000, 4'b0001);  // ch0 samples 4, 20, 36
    expect_pulse(88, 4'b0010, 4'b0000, 4'b0011);  // ch1 samples 56, 72, 88
    run_to(3);
    check("slot_before_tick", 32'(slot), 32'h0);
    run_to(4);
    check("slot_edge4", 32'(slot), 32'h1);
    run_to(8);
    check("slot_edge8", 32'(slot), 32'h2);
    run_to(12);
    check("slot_edge12", 32'(slot), 32'h3);
    run_to(16);
    check("slot_edge16", 32'(slot), 32'h0);
    run_to(30);
    sw_in = 4'b0001;                 // ch1 low for its sample at edge 40
    run_to(35);
    check("clean_before_accept", 32'(clean), 32'h0);
    run_to(37);
    check("rise_one_cycle", 32'(rise), 32'h0);
    check("clean_ch0_pressed", 32'(clean), 32'h1);
    run_to(46);
    sw_in = 4'b0011;                 // ch1 high again from sample at edge 56
    run_to(87);
    check("bounce_not_accepted", 32'(clean), 32'h1);

    // ---- Release ch0 ---------------------------------------------------------
    run_to(90);
    sw_in = 4'b0010;                 // ch0 samples 100, 116, 132
    expect_pulse(132, 4'b0000, 4'b0001, 4'b0010);
    run_to(133);
    check("clean_after_release", 32'(clean), 32'h2);

    // ---- Press again, reset after two samples --------------------------------
    run_to(134);
    sw_in = 4'b0011;                 // ch0 counts at 148 and 164
    run_to(170);
    check("queue_drained_a", q.size(), 0);
    do_reset(4'b0001);
    expect_pulse(36, 4'b0001, 4'b0000, 4'b0001);  // three fresh samples
    run_to(40);
    check("fresh_press_clean", 32'(clean), 32'h1);
    check("queue_drained_b", q.size(), 0);

    // ---- Enable hold between ch0's first and second samples -------------------
    run_to(41);
    do_reset(4'b0001);
    run_to(10);
    check("slot_before_hold", 32'(slot), 32'h2);
    en = 1'b0;                       // edges 11..20 disabled
    run_to(12);
    check("slot_frozen_12", 32'(slot), 32'h2);
    run_to(20);
    check("slot_frozen_20", 32'(slot), 32'h2);
    en = 1'b1;
    run_to(21);
    check("slot_resume_21", 32'(slot), 32'h2);
    run_to(22);
    check("slot_resume_22", 32'(slot), 32'h3);
    expect_pulse(46, 4'b0001, 4'b0000, 4'b0001);  // samples at 4, 30, 46
    run_to(45);
    check("hold_not_early", 32'(clean), 32'h0);
    run_to(46);
    en = 1'b0;                       // pulse must still clear while disabled
    run_to(47);
    check("pulse_clears_disabled", 32'(rise), 32'h0);
    check("clean_held_disabled", 32'(clean), 32'h1);
    run_to(48);
    en = 1'b1;
    check("queue_drained_c", q.size(), 0);

    // ---- All channels together -----------------------------------------------
    do_reset(4'hF);
    expect_pulse(36, 4'b0001, 4'b0000, 4'b0001);
    expect_pulse(40, 4'b0010, 4'b0000, 4'b0011);
    expect_pulse(44, 4'b0100, 4'b0000, 4'b0111);
    expect_pulse(48, 4'b1000, 4'b0000, 4'b1111);
    run_to(48);
    check("all_pressed", 32'(clean), 32'hF);
    sw_in = 4'h0;
    expect_pulse(84, 4'b0000, 4'b0001, 4'b1110);
    expect_pulse(88, 4'b0000, 4'b0010, 4'b1100);
    expect_pulse(92, 4'b0000, 4'b0100, 4'b1000);
    expect_pulse(96, 4'b0000, 4'b1000, 4'b0000);
    run_to(100);
    check("all_released", 32'(clean), 32'h0);
    check("queue_drained_d", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
